sha256_nonce_scheduler: RTL and testbench
=========================================

// Module: sha256_nonce_scheduler
// PURPOSE
//  Sequences one mining job through the 64-stage sha256_3_pipeline: latches midstate/initial digest/header tail,
//  issues one nonce per clock from nonce_start to nonce_end, tracks in-flight results via a latency delay line,
//  tests each digest against a leading-zero target and queues hit nonces. Sits between job host and pipeline.
// PARAMETERS
//  PIPE_LATENCY  66  cycles from pipe_write_en/pipe_block_in sample to matching pipe_digest_out; must match pipeline
//  HIT_DEPTH     4   hit FIFO entries (power of 2; used only with SHA_SCHED_HIT_FIFO_EN)
// PORTS
//  CLK                  in   1    clock, all logic on posedge
//  RST                  in   1    synchronous active-low reset
//  start                in   1    1-cycle pulse: latch job inputs, begin; ignored unless state==IDLE
//  abort                in   1    1-cycle pulse: stop issuing, discard in-flight results
//  digest_initial_in    in   256  initial hash added after round 63 (job constant)
//  midstate_in          in   256  midstate clocked ahead 1 (job constant)
//  block_base_in        in   96   block_in[127:32] (merkle tail, time, bits)
//  nonce_start          in   32   first nonce (block_in[31:0])
//  nonce_end            in   32   last nonce, inclusive
//  zero_bits            in   8    hit if pipe_digest_out[255 -: zero_bits] == 0; 0 => every result hits
//  pipe_write_en        out  1    to pipeline write_en
//  pipe_digest_intial   out  256  to pipeline digest_intial (latched copy)
//  pipe_digest_in       out  256  to pipeline digest_in (latched copy)
//  pipe_block_in        out  128  {block_base, issue_nonce}
//  pipe_digest_out      in   256  from pipeline digest_out
//  busy                 out  1    state != IDLE
//  done                 out  1    1-cycle pulse on return to IDLE after completion (not after abort)
//  hit_valid            out  1    hit_nonce holds an unread hit
//  hit_nonce            out  32   nonce whose digest met target
//  hit_pop              in   1    consume head hit when hit_valid
//  hit_overflow         out  1    sticky: hit dropped because storage full; cleared by start or reset
// BEHAVIOUR
//  Reset (RST==0 at posedge): state IDLE; all outputs 0; delay line, counters, hit storage cleared. Mid-job reset aborts.
//  States: IDLE -start-> ISSUE (or DONE if nonce_end<nonce_start, zero issues) ; ISSUE -last nonce issued-> DRAIN ;
//   DRAIN -delay line empty-> DONE ; DONE -> IDLE (done=1 for this one cycle). abort in ISSUE/DRAIN -> IDLE, no done.
//  ISSUE: pipe_write_en=1, pipe_block_in[31:0]=issue_nonce; issue_nonce starts at nonce_start, +1 per cycle.
//   Termination by equality issue_nonce==nonce_end (last issue), so nonce_end=FFFFFFFF never wraps or reissues.
//   Other states: pipe_write_en=0, pipe_block_in holds last value.
//  Delay line: PIPE_LATENCY-bit shift reg, bit0 = pipe_write_en; tap PIPE_LATENCY-1 marks result valid this cycle.
//   result_nonce counter loads nonce_start on start, +1 on each valid tap (pipeline is in-order, 1/cycle).
//  Hit test (combinational on valid tap): zero_bits>=256 impossible (8-bit max 255); compare top zero_bits bits.
//   Hit pushes result_nonce into storage on same cycle; visible on hit_nonce/hit_valid next cycle.
//  Hit storage survives done/abort; cleared only by reset. start clears hit_overflow only.
//  Simultaneous push+pop when full: pop then push, no overflow. start while busy: ignored. abort while IDLE: no-op.
//  abort and start same cycle in IDLE: start wins. Delay line cleared on abort.
//  Throughput: N=nonce_end-nonce_start+1 nonces issued in N cycles; done at N+PIPE_LATENCY+1 cycles after start.
// CONFIGURATION
//  SHA_SCHED_HIT_FIFO_EN defined: HIT_DEPTH-entry FIFO, head on hit_nonce; overflow when push into full FIFO.
//  Not defined: single hit register; second hit while hit_valid=1 is dropped and sets hit_overflow.
// TESTING
//  T1 job midstate F7A528B9...FA09E776, initial F59007B5...3BC75771, base 252db801130dae516461011a, nonce 3aeb9bb8..3aeb9bb9,
//     zero_bits=0 -> two hits 3aeb9bb8 then 3aeb9bb9 (FIFO) ; pipeline digests DB9E1922... / B677077F... ; done once.
//  T2 same job, zero_bits=1 -> no hits (both digests MSB=1); done at start+2+PIPE_LATENCY+1; hit_overflow=0.
//  T3 nonce_start=FFFFFFFE, nonce_end=FFFFFFFF -> exactly 2 write_en cycles, pipe_block_in[31:0]=FFFFFFFE,FFFFFFFF; done.
//  T4 nonce_end<nonce_start -> no pipe_write_en, done pulse 1 cycle after start; start during busy ignored.
//  T5 abort mid-ISSUE after 10 issues -> write_en drops next cycle, no further hits, no done; RST low mid-job clears all.
//  T6 zero_bits=0, 8-nonce range, no hit_pop -> FIFO holds 4 (or 1 without macro), hit_overflow=1; start clears it.

Source files
------------

// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler
//   Runs one mining job through the sha256_3_pipeline. On start it latches the
//   job constants, issues one nonce per clock from nonce_start to nonce_end, and
//   follows each in-flight result with a latency delay line. Each returning
//   digest is tested against a leading-zero target, and hit nonces are stored.
//
// Optional feature macro: SHA_SCHED_HIT_FIFO_EN
//   defined   : hits are stored in a HIT_DEPTH-entry FIFO, and hit_nonce_o shows the head
//   undefined : hits are stored in a single hit register
//
// Ports
//   clk_i                 clock, all logic on posedge
//   rst_ni                synchronous active-low reset
//   start_i / abort_i     1-cycle job control pulses
//   digest_initial_i      initial hash (job constant)
//   midstate_i            midstate (job constant)
//   block_base_i          block_in[127:32]
//   nonce_start_i         first nonce
//   nonce_end_i           last nonce (inclusive)
//   zero_bits_i           required count of leading zero digest bits
//   pipe_write_en_o       pipeline write enable
//   pipe_digest_intial_o  latched initial digest to the pipeline
//   pipe_digest_in_o      latched midstate to the pipeline
//   pipe_block_in_o       {block_base, issue_nonce} to the pipeline
//   pipe_digest_out_i     digest returned by the pipeline
//   busy_o / done_o       job status
//   hit_valid_o           an unread hit is present
//   hit_nonce_o           nonce of the oldest unread hit
//   hit_pop_i             consume the head hit
//   hit_overflow_o        sticky flag: a hit was dropped
module sha256_nonce_scheduler #(
    parameter int unsigned PIPE_LATENCY = 66,
    parameter int unsigned HIT_DEPTH    = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [255:0] digest_initial_i,
    input  logic [255:0] midstate_i,
    input  logic [95:0]  block_base_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_end_i,
    input  logic [7:0]   zero_bits_i,
    output logic         pipe_write_en_o,
    output logic [255:0] pipe_digest_intial_o,
    output logic [255:0] pipe_digest_in_o,
    output logic [127:0] pipe_block_in_o,
    input  logic [255:0] pipe_digest_out_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         hit_valid_o,
    output logic [31:0]  hit_nonce_o,
    input  logic         hit_pop_i,
    output logic         hit_overflow_o
);

    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned ZB_W     = 8;

    // The pointer arithmetic relies on natural wrap, and the delay line needs at least 2 taps
    if (HIT_DEPTH < 2 || (HIT_DEPTH & (HIT_DEPTH - 1)) != 0) begin : g_bad_hit_depth
        $error("HIT_DEPTH must be a power of two >= 2");
    end
    if (PIPE_LATENCY < 2) begin : g_bad_latency
        $error("PIPE_LATENCY must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [BLOCK_W-1:0]    block_q, block_d;
    logic [DIGEST_W-1:0]   dig_init_q, dig_init_d;
    logic [DIGEST_W-1:0]   midstate_q, midstate_d;
    logic [NONCE_W-1:0]    nonce_end_q, nonce_end_d;
    logic [ZB_W-1:0]       zero_bits_q, zero_bits_d;
    logic [PIPE_LATENCY-1:0] delay_q, delay_d;
    logic [NONCE_W-1:0]    result_nonce_q, result_nonce_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  hit_valid_q, hit_valid_d;
    logic [NONCE_W-1:0]    hit_nonce_q, hit_nonce_d;

    logic                  tap_valid;
    logic                  hit;
    logic                  clear_ovf;
    logic                  ovf_set;
    logic                  hit_pop_ok;
    logic [DIGEST_W-1:0]   hit_mask;

    // A result in the tap during an abort cycle counts as in flight, so it is discarded
    always_comb begin
        tap_valid = delay_q[PIPE_LATENCY-1] &&
                    !(abort_i && (state_q == S_ISSUE || state_q == S_DRAIN));
        hit_mask  = ~({DIGEST_W{1'b1}} >> zero_bits_q);
        hit       = tap_valid && ((pipe_digest_out_i & hit_mask) == '0);
    end

    // Job FSM: next state and datapath
    always_comb begin
        state_d        = state_q;
        wr_en_d        = 1'b0;
        block_d        = block_q;
        dig_init_d     = dig_init_q;
        midstate_d     = midstate_q;
        nonce_end_d    = nonce_end_q;
        zero_bits_d    = zero_bits_q;
        delay_d        = {delay_q[PIPE_LATENCY-2:0], wr_en_q};
        result_nonce_d = tap_valid ? result_nonce_q + NONCE_W'(1) : result_nonce_q;
        clear_ovf      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dig_init_d     = digest_initial_i;
                    midstate_d     = midstate_i;
                    nonce_end_d    = nonce_end_i;
                    zero_bits_d    = zero_bits_i;
                    result_nonce_d = nonce_start_i;
                    clear_ovf      = 1'b1;
                    if (nonce_end_i < nonce_start_i) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        wr_en_d = 1'b1;
                        block_d = {block_base_i, nonce_start_i};
                    end
                end
            end
            S_ISSUE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    delay_d = '0;
                end else if (block_q[NONCE_W-1:0] == nonce_end_q) begin
                    // The nonce on the bus this cycle is the last one, so the counter never wraps
                    state_d = S_DRAIN;
                end else begin
                    wr_en_d = 1'b1;
                    block_d = {block_q[BLOCK_W-1:NONCE_W], block_q[NONCE_W-1:0] + NONCE_W'(1)};
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    delay_d = '0;
                end else if (delay_q[PIPE_LATENCY-2:0] == '0) begin
                    // The only remaining result, if any, sits in the tap this cycle
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);
        overflow_d = clear_ovf ? 1'b0 : (overflow_q | ovf_set);
    end

`ifdef SHA_SCHED_HIT_FIFO_EN
    localparam int unsigned PTR_W = $clog2(HIT_DEPTH);
    localparam int unsigned CNT_W = $clog2(HIT_DEPTH + 1);

    logic [NONCE_W-1:0] mem_q [HIT_DEPTH];
    logic [NONCE_W-1:0] mem_d [HIT_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Hit FIFO: pop is applied before push, so a full FIFO can accept a hit in the same cycle as a pop
    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_set    = 1'b0;
        hit_pop_ok = hit_pop_i && (count_q != '0);
        if (hit_pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
        if (hit) begin
            if (hit_pop_ok || (count_q != CNT_W'(HIT_DEPTH))) begin
                mem_d[wr_ptr_q] = result_nonce_q;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                count_d         = count_d + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end
        hit_valid_d = (count_d != '0);
        hit_nonce_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(HIT_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    // Single hit register: pop is applied before push, and a hit that finds the register occupied is dropped
    always_comb begin
        ovf_set     = 1'b0;
        hit_pop_ok  = hit_pop_i && hit_valid_q;
        hit_valid_d = hit_valid_q && !hit_pop_ok;
        hit_nonce_d = hit_nonce_q;
        if (hit) begin
            if (!hit_valid_d) begin
                hit_valid_d = 1'b1;
                hit_nonce_d = result_nonce_q;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            wr_en_q        <= 1'b0;
            block_q        <= '0;
            dig_init_q     <= '0;
            midstate_q     <= '0;
            nonce_end_q    <= '0;
            zero_bits_q    <= '0;
            delay_q        <= '0;
            result_nonce_q <= '0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            hit_valid_q    <= 1'b0;
            hit_nonce_q    <= '0;
        end else begin
            state_q        <= state_d;
            wr_en_q        <= wr_en_d;
            block_q        <= block_d;
            dig_init_q     <= dig_init_d;
            midstate_q     <= midstate_d;
            nonce_end_q    <= nonce_end_d;
            zero_bits_q    <= zero_bits_d;
            delay_q        <= delay_d;
            result_nonce_q <= result_nonce_d;
            overflow_q     <= overflow_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            hit_valid_q    <= hit_valid_d;
            hit_nonce_q    <= hit_nonce_d;
        end
    end

    assign pipe_write_en_o      = wr_en_q;
    assign pipe_block_in_o      = block_q;
    assign pipe_digest_intial_o = dig_init_q;
    assign pipe_digest_in_o     = midstate_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign hit_valid_o          = hit_valid_q;
    assign hit_nonce_o          = hit_nonce_q;
    assign hit_overflow_o       = overflow_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Testbench for sha256_nonce_scheduler. A behavioural pipeline stand-in returns
// chosen digests PIPE_LATENCY cycles after each write. Expected hit nonces go
// into a scoreboard queue, and a negedge monitor pops and compares them.
module tb_sha256_nonce_scheduler;

    localparam int unsigned LAT = 66;
`ifdef SHA_SCHED_HIT_FIFO_EN
    localparam int unsigned STORE = 4;
`else
    localparam int unsigned STORE = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, abort, hit_pop;
    logic [255:0] dinit, mid;
    logic [95:0]  base;
    logic [31:0]  ns, ne;
    logic [7:0]   zb;
    logic         wr_en;
    logic [255:0] p_init, p_mid, p_dout;
    logic [127:0] blk;
    logic         busy, done, hit_valid, hit_ovf;
    logic [31:0]  hit_nonce;

    always #5 clk = ~clk;

    sha256_nonce_scheduler #(.PIPE_LATENCY(LAT), .HIT_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .digest_initial_i(dinit), .midstate_i(mid), .block_base_i(base),
        .nonce_start_i(ns), .nonce_end_i(ne), .zero_bits_i(zb),
        .pipe_write_en_o(wr_en), .pipe_digest_intial_o(p_init),
        .pipe_digest_in_o(p_mid), .pipe_block_in_o(blk),
        .pipe_digest_out_i(p_dout), .busy_o(busy), .done_o(done),
        .hit_valid_o(hit_valid), .hit_nonce_o(hit_nonce),
        .hit_pop_i(hit_pop), .hit_overflow_o(hit_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    bit pop_en   = 1'b0;
    logic [31:0] issued[$];
    logic [31:0] exp_hits[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Known digests for the T1 job; other nonces return {nonce, filler}, so leading zeros follow the nonce
    function automatic logic [255:0] dig(input logic [31:0] n);
        if (n == 32'h3aeb9bb8)
            return 256'hDB9E1922_4F1A2B3C_5D6E7F80_91A2B3C4_D5E6F708_192A3B4C_5D6E7F80_91A2B3C4;
        else if (n == 32'h3aeb9bb9)
            return 256'hB677077F_4F1A2B3C_5D6E7F80_91A2B3C4_D5E6F708_192A3B4C_5D6E7F80_91A2B3C4;
        else
            return {n, 224'hC3C3C3C3_C3C3C3C3_C3C3C3C3_C3C3C3C3_C3C3C3C3_C3C3C3C3_C3C3C3C3};
    endfunction

    // Pipeline stand-in: a write in cycle c is returned on digest_out in cycle c+LAT
    logic        pv [LAT];
    logic [31:0] pn [LAT];
    initial for (int i = 0; i < int'(LAT); i++) begin pv[i] = 1'b0; pn[i] = '0; end
    always @(posedge clk) begin
        pv[0] <= wr_en;
        pn[0] <= blk[31:0];
        for (int i = 1; i < int'(LAT); i++) begin
            pv[i] <= pv[i-1];
            pn[i] <= pn[i-1];
        end
    end
    assign p_dout = pv[LAT-1] ? dig(pn[LAT-1]) : {256{1'b1}};

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: records issues and done pulses, and checks hits against the scoreboard
    always @(negedge clk) begin
        hit_pop = 1'b0;
        if (wr_en) issued.push_back(blk[31:0]);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst_n && pop_en && hit_valid) begin
            if (exp_hits.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_hit: got %0h expected none", hit_nonce);
            end else begin
                check("hit_nonce", hit_nonce, exp_hits.pop_front());
            end
            hit_pop = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] e, input logic [7:0] z, output int scyc);
        ns = s; ne = e; zb = z;
        issued.delete();
        start = 1'b1;
        scyc  = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int maxc, input string name);
        int i = 0;
        while (done_cnt == prev && i < maxc) begin
            tick();
            i++;
        end
        if (done_cnt == prev) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no done within %0d cycles expected done", name, maxc);
        end
    endtask

    task automatic check_issued(input string name, input logic [31:0] first, input int n);
        check({name, "_count"}, 256'(issued.size()), 256'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] got;
            got = (i < issued.size()) ? issued[i] : 32'hDEADBEEF;
            check({name, "_nonce"}, 256'(got), 256'(first + 32'(i)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, d0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hit_pop = 1'b0;
        dinit = '0; mid = '0; base = '0; ns = '0; ne = '0; zb = '0;
        tick(3);
        rst_n = 1'b1;
        tick();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_wr_en", 256'(wr_en), 256'(0));
        check("rst_hit_valid", 256'(hit_valid), 256'(0));
        check("rst_overflow", 256'(hit_ovf), 256'(0));
        check("rst_block", 256'(blk), 256'(0));

        // T1: zero_bits=0, two nonces, both hit in order
        mid   = 256'hF7A528B9_3C1D5E7F_11223344_55667788_99AABBCC_DDEEFF00_0F1E2D3C_FA09E776;
        dinit = 256'hF59007B5_6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_3BC75771;
        base  = 96'h252db801130dae516461011a;
        pop_en = 1'b1;
        exp_hits.push_back(32'h3aeb9bb8);
        exp_hits.push_back(32'h3aeb9bb9);
        d0 = done_cnt;
        go(32'h3aeb9bb8, 32'h3aeb9bb9, 8'd0, s);
        check("t1_busy", 256'(busy), 256'(1));
        check("t1_digest_in", p_mid, mid);
        check("t1_digest_intial", p_init, dinit);
        check("t1_block_base", 256'(blk[127:32]), 256'(base));
        wait_done(d0, 200, "t1_done_wait");
        check("t1_done_cycle", 256'(done_cyc), 256'(s + 2 + LAT + 1));
        check_issued("t1_issue", 32'h3aeb9bb8, 2);
        tick(3);
        check("t1_done_once", 256'(done_cnt), 256'(d0 + 1));
        check("t1_hits_drained", 256'(exp_hits.size()), 256'(0));
        check("t1_busy_end", 256'(busy), 256'(0));

        // T2: zero_bits=1, both digests have MSB set, so there are no hits
        d0 = done_cnt;
        go(32'h3aeb9bb8, 32'h3aeb9bb9, 8'd1, s);
        wait_done(d0, 200, "t2_done_wait");
        check("t2_done_cycle", 256'(done_cyc), 256'(s + 2 + LAT + 1));
        tick(3);
        check("t2_hit_valid", 256'(hit_valid), 256'(0));
        check("t2_overflow", 256'(hit_ovf), 256'(0));

        // T3: top of nonce space, no wrap
        d0 = done_cnt;
        go(32'hFFFFFFFE, 32'hFFFFFFFF, 8'd1, s);
        wait_done(d0, 200, "t3_done_wait");
        check("t3_done_cycle", 256'(done_cyc), 256'(s + 2 + LAT + 1));
        tick(3);
        check_issued("t3_issue", 32'hFFFFFFFE, 2);
        check("t3_done_once", 256'(done_cnt), 256'(d0 + 1));

        // T7: zero_bits=8 over a top-byte boundary; a start while busy is ignored
        exp_hits.push_back(32'h00FFFFFE);
        exp_hits.push_back(32'h00FFFFFF);
        d0 = done_cnt;
        go(32'h00FFFFFE, 32'h01000001, 8'd8, s);
        ns = 32'h0; ne = 32'h10; zb = 8'd0; start = 1'b1;
        tick();
        start = 1'b0; ns = 32'h00FFFFFE; ne = 32'h01000001; zb = 8'd8;
        wait_done(d0, 200, "t7_done_wait");
        check("t7_done_cycle", 256'(done_cyc), 256'(s + 4 + LAT + 1));
        tick(3);
        check_issued("t7_issue", 32'h00FFFFFE, 4);
        check("t7_hits_drained", 256'(exp_hits.size()), 256'(0));

        // T5a: abort after 10 issues; the remaining in-flight results are discarded
        d0 = done_cnt;
        go(32'h100, 32'h1FF, 8'd0, s);
        tick(9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_wr_en_after_abort", 256'(wr_en), 256'(0));
        check("t5_busy_after_abort", 256'(busy), 256'(0));
        tick(LAT + 14);
        check("t5_issue_count", 256'(issued.size()), 256'(10));
        check("t5_no_done", 256'(done_cnt), 256'(d0));
        check("t5_hit_valid", 256'(hit_valid), 256'(0));

        // T5b: reset mid-job clears everything
        go(32'h200, 32'h2FF, 8'd0, s);
        tick(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_wr_en", 256'(wr_en), 256'(0));
        check("t5_rst_busy", 256'(busy), 256'(0));
        check("t5_rst_block", 256'(blk), 256'(0));
        check("t5_rst_digest_in", p_mid, 256'(0));
        check("t5_rst_digest_intial", p_init, 256'(0));
        tick(LAT + 14);
        check("t5_rst_issue_count", 256'(issued.size()), 256'(6));
        check("t5_rst_no_done", 256'(done_cnt), 256'(d0));
        check("t5_rst_hit_valid", 256'(hit_valid), 256'(0));

        // T6: eight hits with no pops, so storage fills and overflow sets
        pop_en = 1'b0;
        d0 = done_cnt;
        go(32'h10, 32'h17, 8'd0, s);
        wait_done(d0, 200, "t6_done_wait");
        check("t6_done_cycle", 256'(done_cyc), 256'(s + 8 + LAT + 1));
        tick(2);
        check("t6_hit_valid", 256'(hit_valid), 256'(1));
        check("t6_head", 256'(hit_nonce), 256'(32'h10));
        check("t6_overflow", 256'(hit_ovf), 256'(1));
        for (int i = 0; i < int'(STORE); i++) exp_hits.push_back(32'h10 + 32'(i));
        pop_en = 1'b1;
        tick(8);
        check("t6_hits_drained", 256'(exp_hits.size()), 256'(0));
        check("t6_empty", 256'(hit_valid), 256'(0));
        check("t6_overflow_sticky", 256'(hit_ovf), 256'(1));

        // T4: empty range, done one cycle after start, and start clears overflow
        d0 = done_cnt;
        go(32'h5, 32'h4, 8'd0, s);
        wait_done(d0, 10, "t4_done_wait");
        check("t4_done_cycle", 256'(done_cyc), 256'(s + 1));
        tick(3);
        check("t4_issue_count", 256'(issued.size()), 256'(0));
        check("t4_overflow_cleared", 256'(hit_ovf), 256'(0));
        check("t4_done_once", 256'(done_cnt), 256'(d0 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
